p405s_timer_time_base: RTL

//  64-bit PowerPC time base (TBU:TBL) with free-run or external-timer-clock increment.

---
 rtl/p405s_timer_time_base.sv | 101 ++++++++++
 1 files changed

// File: rtl/p405s_timer_time_base.sv
// 64-bit time base (TBU:TBL) counting every core clock or on synchronized external
// timer clock edges, with FIT/watchdog tap vectors and one-cycle tap delay registers.
module p405s_timer_time_base #(
  parameter int SYNC_STAGES  = 2,
  parameter int FIT_BASE_IDX = 23,
  parameter int WD_BASE_IDX  = 15,
  parameter int TAP_STRIDE   = 4
) (
  input  logic        CB,
  input  logic        resetL,
  input  logic        tbEnable,
  input  logic        extTimerClkSel,
  input  logic        TIM_timerClk,
  input  logic        tblWrEn,
  input  logic        tbuWrEn,
  input  logic [0:31] tbWrData,
  input  logic        wdTapsIn,
  input  logic        fitTapsIn,
  output logic [0:31] tbl,
  output logic [0:31] tbu,
  output logic [0:3]  fitTaps,
  output logic [0:3]  wdTaps,
  output logic        fitDlyL2,
  output logic        wdDlyL2,
  output logic        tbCarry
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic [0:31]            tbl_reg, tbl_next;
  logic [0:31]            tbu_reg, tbu_next;
  logic                   carry_reg, carry_next;
  logic                   fit_dly_reg, wd_dly_reg;
  logic                   ext_edge, tick, wrap;

  // Synchronizer and history run unconditionally so a mode switch never fakes an edge.
  always_ff @(posedge CB or negedge resetL) begin
    if (!resetL) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], TIM_timerClk};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign ext_edge = sync_reg[SYNC_STAGES-1] & ~hist_reg;
  assign tick     = tbEnable & (extTimerClkSel ? ext_edge : 1'b1);
  assign wrap     = tick & (tbl_reg == 32'hFFFF_FFFF);

  // A TBL write swallows both the increment and the carry; a TBU write swallows the carry.
  always_comb begin
    tbl_next   = tbl_reg;
    tbu_next   = tbu_reg;
    carry_next = 1'b0;
    if (tblWrEn) begin
      tbl_next = tbWrData;
    end else if (tick) begin
      tbl_next = tbl_reg + 32'd1;
    end
    if (tbuWrEn) begin
      tbu_next = tbWrData;
    end else if (wrap && !tblWrEn) begin
      tbu_next   = tbu_reg + 32'd1;
      carry_next = 1'b1;
    end
  end

  always_ff @(posedge CB or negedge resetL) begin
    if (!resetL) begin
      tbl_reg     <= '0;
      tbu_reg     <= '0;
      carry_reg   <= 1'b0;
      fit_dly_reg <= 1'b0;
      wd_dly_reg  <= 1'b0;
    end else begin
      tbl_reg     <= tbl_next;
      tbu_reg     <= tbu_next;
      carry_reg   <= carry_next;
      fit_dly_reg <= fitTapsIn;
      wd_dly_reg  <= wdTapsIn;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_taps
      localparam int FIT_IDX = FIT_BASE_IDX - gi * TAP_STRIDE;
      localparam int WD_IDX  = WD_BASE_IDX - gi * TAP_STRIDE;
      assign fitTaps[gi] = tbl_reg[FIT_IDX];
      assign wdTaps[gi]  = tbl_reg[WD_IDX];
    end
  endgenerate

  assign tbl      = tbl_reg;
  assign tbu      = tbu_reg;
  assign tbCarry  = carry_reg;
  assign fitDlyL2 = fit_dly_reg;
  assign wdDlyL2  = wd_dly_reg;

endmodule
